// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified memory port: default widths and the
// response-owner encoding used by the arbiter's response register.
package mem_port_arbiter_pkg;

   localparam int unsigned MEM_ADDR_W = 16;
   localparam int unsigned MEM_DATA_W = 16;

   localparam int unsigned WAIT_W = 4;
   localparam logic [WAIT_W-1:0] WAIT_SAT = 4'hf;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_EXT  = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating starvation counter for the external requester; flags when the
// count has reached the configured wait limit.
module arb_starve_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              clear,
   output logic [WAIT_W-1:0] count,
   output logic              at_limit
);

   logic [WAIT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != WAIT_SAT)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count    = count_q;
   assign at_limit = (32'(count_q) >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-way arbiter for the single memory port: CPU has priority, the external
// requester wins a slot after EXT_MAX_WAIT denied cycles or whenever ext_hold is set.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = MEM_ADDR_W,
   parameter int unsigned DATA_W       = MEM_DATA_W,
   parameter int unsigned EXT_MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   input  logic              ext_hold,
   output logic              ext_gnt,
   output logic              ext_ack,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [3:0]        wait_cnt
);

   logic              ext_at_limit;
   logic [1:0]        owner_q, owner_d;
   logic              we_q;
   logic [DATA_W-1:0] cpu_rdata_q, ext_rdata_q;

   arb_starve_counter #(
      .LIMIT (EXT_MAX_WAIT)
   ) u_starve (
      .clk      (clk),
      .reset    (reset),
      .inc      (ext_req & ~ext_gnt),
      .clear    (ext_gnt),
      .count    (wait_cnt),
      .at_limit (ext_at_limit)
   );

   // Grants are gated by reset so nothing reaches memory while reset is low.
   always_comb begin
      cpu_gnt = 1'b0;
      ext_gnt = 1'b0;
      if (reset) begin
         if (ext_hold) begin
            ext_gnt = ext_req;
         end else if (ext_req && ext_at_limit) begin
            ext_gnt = 1'b1;
         end else if (cpu_req) begin
            cpu_gnt = 1'b1;
         end else if (ext_req) begin
            ext_gnt = 1'b1;
         end
      end
   end

   assign cpu_stall = reset & cpu_req & ~cpu_gnt;

   assign mem_en    = cpu_gnt | ext_gnt;
   assign mem_we    = ext_gnt ? ext_we : (cpu_gnt & cpu_we);
   assign mem_addr  = ext_gnt ? ext_addr : cpu_addr;
   assign mem_wdata = ext_gnt ? ext_wdata : cpu_wdata;

   always_comb begin
      owner_d = OWN_NONE;
      if (cpu_gnt) begin
         owner_d = OWN_CPU;
      end else if (ext_gnt) begin
         owner_d = OWN_EXT;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q <= OWN_NONE;
         we_q    <= 1'b0;
      end else begin
         owner_q <= owner_d;
         we_q    <= mem_we;
      end
   end

   assign cpu_ack = (owner_q == OWN_CPU);
   assign ext_ack = (owner_q == OWN_EXT);

   // Read data passes straight through in the ack cycle, then is held.
   assign cpu_rdata = (cpu_ack && !we_q) ? mem_rdata : cpu_rdata_q;
   assign ext_rdata = (ext_ack && !we_q) ? mem_rdata : ext_rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_rdata_q <= '0;
         ext_rdata_q <= '0;
      end else begin
         cpu_rdata_q <= cpu_rdata;
         ext_rdata_q <= ext_rdata;
      end
   end

endmodule
